// File: rtl/clk_sync_pkg.sv
// Shared types and constants for the clk_sync_sched strobe scheduler.
package clk_sync_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  localparam int unsigned GAP_DEF = 8;
  localparam int unsigned GAP_W   = clog2(GAP_DEF);

endpackage

// File: rtl/clk_sync_rr_arb.sv
// Combinational round-robin pick: first set pending bit above 'last', with wrap.
module clk_sync_rr_arb
  import clk_sync_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] pending,
  input  logic [IDW-1:0]  last,
  output logic            gnt_valid,
  output logic [IDW-1:0]  gnt_idx
);

  int unsigned c;

  // Scan last+1 .. last+NREQ modulo NREQ; the first hit wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    c         = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      c = (32'(last) + i) % NREQ;
      if (!gnt_valid && pending[c]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDW'(c);
      end
    end
  end

endmodule

// File: rtl/clk_sync_sched.sv
// Schedules NREQ single-cycle clk1 events onto one toggle-synchronizer channel.
// Optional per-source drop counters: define CLK_SYNC_SCHED_DROPCNT_EN.
module clk_sync_sched
  import clk_sync_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2,
  parameter int unsigned GAP  = 8
`ifdef CLK_SYNC_SCHED_DROPCNT_EN
  ,
  parameter int unsigned DCW  = 8
`endif
) (
  input  logic                clk1,
  input  logic                rst1_n,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     mask,
  output logic                sync_pulse,
  output logic [IDW-1:0]      sync_id,
  output logic                busy,
  output logic [NREQ-1:0]     pending
`ifdef CLK_SYNC_SCHED_DROPCNT_EN
  ,
  output logic [NREQ*DCW-1:0] drop_cnt
`endif
);

  // Hold counter only needs to reach GAP-1; keep at least one bit for GAP=1.
  localparam int unsigned HCW = (clog2(GAP) > 0) ? clog2(GAP) : 1;

  state_t              state, state_n;
  logic [IDW-1:0]      last, last_n;
  logic [HCW-1:0]      hold, hold_n;
  logic                pulse_n, busy_n;
  logic [IDW-1:0]      id_n;
  logic [NREQ-1:0]     pend_n;
  logic [NREQ-1:0]     gnt_vec;
  logic                gnt_valid;
  logic [IDW-1:0]      gnt_idx;

  clk_sync_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .pending   (pending),
    .last      (last),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Next-state, registered-output and pending-bit logic.
  always_comb begin
    state_n = state;
    last_n  = last;
    hold_n  = hold;
    pulse_n = 1'b0;
    id_n    = sync_id;
    gnt_vec = '0;
    unique case (state)
      IDLE: begin
        if (gnt_valid) begin
          pulse_n          = 1'b1;
          id_n             = gnt_idx;
          last_n           = gnt_idx;
          gnt_vec[gnt_idx] = 1'b1;
          state_n          = ISSUE;
        end
      end
      ISSUE: begin
        hold_n  = HCW'(GAP - 1);
        state_n = HOLD;
      end
      HOLD: begin
        if (hold == '0) state_n = IDLE;
        else            hold_n  = hold - 1'b1;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
    // A same-cycle req on the granted source keeps its bit; mask wins over all.
    pend_n = mask & (req | (pending & ~gnt_vec));
  end

`ifdef CLK_SYNC_SCHED_DROPCNT_EN
  logic [NREQ*DCW-1:0] drop_n;

  // Count events that fold into an already-pending, not-granted slot; saturating.
  always_comb begin
    drop_n = drop_cnt;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (req[k] && mask[k] && pending[k] && !gnt_vec[k] &&
          (drop_cnt[k*DCW +: DCW] != '1))
        drop_n[k*DCW +: DCW] = drop_cnt[k*DCW +: DCW] + 1'b1;
    end
  end

  // Drop counter register; cleared only by reset.
  always_ff @(posedge clk1) begin
    if (!rst1_n) drop_cnt <= '0;
    else         drop_cnt <= drop_n;
  end
`endif

  // State and output registers.
  always_ff @(posedge clk1) begin
    if (!rst1_n) begin
      state      <= IDLE;
      last       <= IDW'(NREQ - 1);
      hold       <= '0;
      sync_pulse <= 1'b0;
      sync_id    <= '0;
      busy       <= 1'b0;
      pending    <= '0;
    end else begin
      state      <= state_n;
      last       <= last_n;
      hold       <= hold_n;
      sync_pulse <= pulse_n;
      sync_id    <= id_n;
      busy       <= busy_n;
      pending    <= pend_n;
    end
  end

endmodule
